// File: rtl/riscv_core_axi_pkg.sv
// rtl/riscv_core_axi_pkg.sv - AXI constants and refill FSM types shared by the I-cache refill master
package riscv_core_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        REFILL_IDLE,
        REFILL_ADDR,
        REFILL_DATA,
        REFILL_DONE
    } refill_state_e;

    // AxSIZE encoding: log2 of the beat size in bytes
    function automatic logic [2:0] axi_size(input int data_width);
        logic [2:0] size;
        size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/riscv_core_icache_axi_refill.sv
// rtl/riscv_core_icache_axi_refill.sv - AXI4 read master refilling one I-cache block per request
module riscv_core_icache_axi_refill
    import riscv_core_axi_pkg::*;
#(
    parameter int                      ADDR_WIDTH     = 64,
    parameter int                      BLOCK_WIDTH    = 256,
    parameter int                      AXI_DATA_WIDTH = 64,
    parameter int                      AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      o_mem_done,
    output logic                      o_mem_err,
    output logic [BLOCK_WIDTH-1:0]    o_block,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_ID_WIDTH-1:0]   i_rid,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready
);

    localparam int                    BEATS     = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int                    CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

    assign o_arid    = AXI_ID;
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = axi_size(AXI_DATA_WIDTH);
    assign o_arburst = AXI_BURST_INCR;

    refill_state_e          state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   err_flag, err_flag_d;
    logic [ADDR_WIDTH-1:0]  araddr_d;
    logic                   arvalid_d, rready_d, done_d, err_d;
    logic                   beat, beat_err;

    // o_rready is high for the whole of DATA, so a valid beat there is a handshake
    assign beat     = (state == REFILL_DATA) && i_rvalid;
    assign beat_err = (i_rresp != AXI_RESP_OKAY) || (i_rid != AXI_ID) ||
                      (i_rlast != (cnt == LAST_BEAT));

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        err_flag_d = err_flag;
        araddr_d   = o_araddr;
        case (state)
            REFILL_IDLE: begin
                if (i_mem_req) begin
                    araddr_d   = i_addr & ~OFF_MASK;
                    cnt_d      = '0;
                    err_flag_d = 1'b0;
                    state_d    = REFILL_ADDR;
                end
            end
            REFILL_ADDR: begin
                if (i_arready) begin
                    state_d = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                if (beat) begin
                    err_flag_d = err_flag | beat_err;
                    if (cnt == LAST_BEAT) begin
                        state_d = REFILL_DONE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            REFILL_DONE: begin
                state_d = REFILL_IDLE;
            end
            default: begin
                state_d = REFILL_IDLE;
            end
        endcase
        arvalid_d = (state_d == REFILL_ADDR);
        rready_d  = (state_d == REFILL_DATA);
        done_d    = (state_d == REFILL_DONE);
        err_d     = (state_d == REFILL_DONE) && err_flag_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= REFILL_IDLE;
            cnt        <= '0;
            err_flag   <= 1'b0;
            o_araddr   <= '0;
            o_arvalid  <= 1'b0;
            o_rready   <= 1'b0;
            o_mem_done <= 1'b0;
            o_mem_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            err_flag   <= err_flag_d;
            o_araddr   <= araddr_d;
            o_arvalid  <= arvalid_d;
            o_rready   <= rready_d;
            o_mem_done <= done_d;
            o_mem_err  <= err_d;
        end
    end

    // Beat assembler: slot k is only written by beat k, so the line holds after DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_block <= '0;
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat && (cnt == CNT_W'(k))) begin
                    o_block[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_icache_axi_refill.sv
// tb/tb_riscv_core_icache_axi_refill.sv - self-checking bench for the I-cache AXI refill master
module tb_riscv_core_icache_axi_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [63:0]  addr;
    logic         mem_done, mem_err;
    logic [255:0] block;
    logic [3:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    always #5 clk = ~clk;

    riscv_core_icache_axi_refill dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_mem_req  (mem_req),
        .i_addr     (addr),
        .o_mem_done (mem_done),
        .o_mem_err  (mem_err),
        .o_block    (block),
        .o_arid     (arid),
        .o_araddr   (araddr),
        .o_arlen    (arlen),
        .o_arsize   (arsize),
        .o_arburst  (arburst),
        .o_arvalid  (arvalid),
        .i_arready  (arready),
        .i_rid      (rid),
        .i_rdata    (rdata),
        .i_rresp    (rresp),
        .i_rlast    (rlast),
        .i_rvalid   (rvalid),
        .o_rready   (rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] beat_data [4];
    logic [1:0]  beat_resp [4];
    logic [3:0]  beat_id   [4];
    logic        beat_last [4];
    int          beat_gap  [4];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clean_beats();
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = {$urandom, $urandom};
            beat_resp[k] = 2'b00;
            beat_id[k]   = 4'd0;
            beat_last[k] = (k == 3);
            beat_gap[k]  = 0;
        end
    endtask

    // One refill as a well-behaved slave; rst_before < 0 means run to completion
    task automatic run_refill(input logic [63:0] req_addr, input int ar_wait, input int rst_before);
        logic [63:0]  exp_addr;
        logic [255:0] exp_block;
        logic         exp_err;
        int           hs;
        exp_addr  = req_addr & ~64'h1f;
        exp_err   = 1'b0;
        exp_block = '0;
        hs        = 0;
        for (int k = 0; k < 4; k++) begin
            exp_block[k*64 +: 64] = beat_data[k];
            if (beat_resp[k] != 2'b00 || beat_id[k] != 4'd0 || beat_last[k] != (k == 3))
                exp_err = 1'b1;
        end

        mem_req = 1'b1;
        addr    = req_addr;
        step();
        for (int w = 0; w <= ar_wait; w++) begin
            arready = (w == ar_wait);
            addr    = {$urandom, $urandom};
            check("arvalid_hold", arvalid, 1'b1);
            check("araddr", araddr, exp_addr);
            check("rready_before_ar", rready, 1'b0);
            if (arvalid && arready) hs++;
            step();
        end
        arready = 1'b0;
        check("ar_handshakes", hs, 1);
        check("arvalid_drop", arvalid, 1'b0);
        check("arlen", arlen, 8'd3);
        check("arsize", arsize, 3'd3);
        check("arburst", arburst, 2'b01);
        check("arid", arid, 4'd0);

        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < beat_gap[k]; g++) begin
                rvalid = 1'b0;
                rdata  = {$urandom, $urandom};
                rlast  = 1'($urandom);
                rresp  = 2'($urandom);
                check("rready_gap", rready, 1'b1);
                check("done_early", mem_done, 1'b0);
                step();
            end
            if (k == rst_before) begin
                #1 rst = 1'b1;
                #1;
                check("rst_arvalid", arvalid, 1'b0);
                check("rst_rready", rready, 1'b0);
                check("rst_done", mem_done, 1'b0);
                check("rst_block", block, 256'd0);
                mem_req = 1'b0;
                step();
                rst = 1'b0;
                step();
                return;
            end
            rvalid = 1'b1;
            rdata  = beat_data[k];
            rresp  = beat_resp[k];
            rid    = beat_id[k];
            rlast  = beat_last[k];
            check("rready_beat", rready, 1'b1);
            step();
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            rid    = 4'd0;
        end

        check("done_pulse", mem_done, 1'b1);
        check("err_pulse", mem_err, exp_err);
        check("block", block, exp_block);
        check("rready_after", rready, 1'b0);
        mem_req = 1'b0;
        step();
        check("done_single", mem_done, 1'b0);
        check("err_single", mem_err, 1'b0);
        check("block_hold", block, exp_block);
        step();
        check("no_double_refill", arvalid, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        mem_req = 1'b0;
        addr    = '0;
        arready = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        step();
        check("reset_arvalid", arvalid, 1'b0);
        check("reset_rready", rready, 1'b0);
        check("reset_done", mem_done, 1'b0);
        check("reset_err", mem_err, 1'b0);
        check("reset_araddr", araddr, 64'd0);
        check("reset_block", block, 256'd0);
        rst = 1'b0;
        step();

        // basic refill
        clean_beats();
        beat_data[0] = 64'h1111_1111_1111_1111;
        beat_data[1] = 64'h2222_2222_2222_2222;
        beat_data[2] = 64'h3333_3333_3333_3333;
        beat_data[3] = 64'h4444_4444_4444_4444;
        run_refill(64'h8000_1234, 0, -1);

        // AR backpressure
        clean_beats();
        run_refill(64'h0000_0000_dead_beef, 5, -1);

        // R gaps: rvalid 1,0,0,1,0,1,1
        clean_beats();
        beat_gap[1] = 2;
        beat_gap[2] = 1;
        run_refill(64'h1234_5678_9abc_def0, 1, -1);

        // SLVERR on beat 2
        clean_beats();
        beat_resp[2] = 2'b10;
        run_refill(64'h0000_0040_0000_001f, 0, -1);

        // early rlast, then missing rlast
        clean_beats();
        beat_last[1] = 1'b1;
        run_refill(64'h0000_0000_0000_0020, 0, -1);
        clean_beats();
        beat_last[3] = 1'b0;
        run_refill(64'hffff_ffff_ffff_ffff, 2, -1);

        // reset after two beats, then a clean refill
        clean_beats();
        run_refill(64'h0000_0000_0001_0000, 0, 2);
        clean_beats();
        run_refill(64'h0000_0000_0002_0008, 0, -1);

        for (int i = 0; i < 40; i++) begin
            clean_beats();
            for (int k = 0; k < 4; k++) begin
                beat_gap[k] = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) beat_resp[k] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) beat_id[k] = 4'($urandom_range(1, 15));
                if ($urandom_range(0, 15) == 0) beat_last[k] = ~beat_last[k];
            end
            run_refill({$urandom, $urandom}, $urandom_range(0, 4), -1);
            for (int j = $urandom_range(0, 2); j > 0; j--) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
